// File: rtl/branch_pkg.sv
// Shared definitions for the branch-offset encoding path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default field/address widths, the legal byte-offset window for
// those defaults, and the packed response record used by consumers of the
// encoder and the assembler checker.
package branch_pkg;

  // Default width of the encoded signed word-offset field.
  localparam int OFFSET_W_DEF = 8;

  // Default byte-address width.
  localparam int ADDR_W_DEF = 32;

  // Legal byte-offset window (TARGET - PC_PLUS4) for the default field width.
  // The field counts words, so the byte range is the signed field range * 4:
  // -128*4 = -512 up to +127*4 = +508.
  localparam int MIN_BYTE_OFFSET = -(1 << (OFFSET_W_DEF + 1));
  localparam int MAX_BYTE_OFFSET = (1 << (OFFSET_W_DEF + 1)) - 4;

  // One encoded result: the truncated offset plus both error flags.
  typedef struct packed {
    logic [OFFSET_W_DEF-1:0] offset;
    logic                    align_err;
    logic                    range_err;
  } rsp_t;

endpackage : branch_pkg

// File: rtl/offset_range_check.sv
// Encodes a byte difference into a signed word offset and flags range/alignment faults.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   diff      in  ADDR_W    byte difference TARGET - PC_PLUS4 (modulo 2^ADDR_W)
//   offset    out OFFSET_W  diff[OFFSET_W+1:2]; truncated bits even when an error is flagged
//   align_err out 1         diff is not a multiple of 4
//   range_err out 1         word offset does not fit a signed OFFSET_W-bit field
module offset_range_check
  import branch_pkg::*;
#(
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]   diff,
  output logic [OFFSET_W-1:0] offset,
  output logic                align_err,
  output logic                range_err
);

  // Bits from the field's sign bit up to the MSB of the difference. The
  // slice deliberately includes diff[OFFSET_W+1] itself, so "every bit equal
  // to the field sign" reduces to "slice is all ones or all zeros".
  localparam int UPPER_W = ADDR_W - OFFSET_W - 1;

  logic [UPPER_W-1:0] upper;

  assign upper     = diff[ADDR_W-1:OFFSET_W+1];
  assign offset    = diff[OFFSET_W+1:2];
  assign align_err = |diff[1:0];
  // Sign extension of the field reproduces diff only if no upper bit differs.
  assign range_err = !((&upper) || !(|upper));

endmodule : offset_range_check

// File: rtl/branch_offset_encoder.sv
// Two-stage pipeline turning a branch target address into an encoded word offset.
// Latency: response valid one edge after the accepting edge when the output stage is free.
// Backpressure: valid/ready; REQ_READY drops only when both stages are full and RSP_READY is low.
//
// Ports:
//   CLK        in  1         sole clock, rising edge
//   RESET      in  1         asynchronous, active-high reset
//   REQ_VALID  in  1         request present
//   REQ_READY  out 1         request accepted this cycle (no path from REQ_VALID)
//   PC_PLUS4   in  ADDR_W    address of the instruction after the branch
//   TARGET     in  ADDR_W    branch target byte address
//   RSP_VALID  out 1         response present
//   RSP_READY  in  1         consumer takes the response
//   OFFSET     out OFFSET_W  encoded word offset, meaningful only without error flags
//   ALIGN_ERR  out 1         target - PC_PLUS4 not a multiple of 4
//   RANGE_ERR  out 1         word offset does not fit the signed field
//   ERR_COUNT  out 8         saturating count of erroneous responses handed off
module branch_offset_encoder
  import branch_pkg::*;
#(
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [ADDR_W-1:0]   PC_PLUS4,
  input  logic [ADDR_W-1:0]   TARGET,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [OFFSET_W-1:0] OFFSET,
  output logic                ALIGN_ERR,
  output logic                RANGE_ERR,
  output logic [7:0]          ERR_COUNT
);

  // Stage 1: raw byte difference.
  logic              v1;
  logic [ADDR_W-1:0] diff_q;

  // Stage 2: valid bit for the output register (payload lives in the outputs).
  logic              v2;

  // Stage-advance enables.
  logic adv1;
  logic adv2;

  // Combinational encode of stage-1 contents.
  logic [OFFSET_W-1:0] chk_offset;
  logic                chk_align;
  logic                chk_range;

  logic rsp_xfer;

  // The output stage can take new data when it is empty or being drained;
  // stage 1 can refill when it is empty or moving forward. Stage 1 moves
  // forward whenever stage 2 can take it, so a bubble is never parked in
  // front of an empty output stage.
  assign adv2      = !v2 || RSP_READY;
  assign adv1      = !v1 || adv2;
  assign REQ_READY = adv1;
  assign RSP_VALID = v2;
  assign rsp_xfer  = v2 && RSP_READY;

  offset_range_check #(
    .OFFSET_W (OFFSET_W),
    .ADDR_W   (ADDR_W)
  ) u_check (
    .diff      (diff_q),
    .offset    (chk_offset),
    .align_err (chk_align),
    .range_err (chk_range)
  );

  // Stage 1 register. The difference wraps modulo 2^ADDR_W, which is what
  // makes e.g. PC 0 -> target 0xFFFF_FFFC come out as -4.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      v1     <= 1'b0;
      diff_q <= '0;
    end else if (adv1) begin
      v1 <= REQ_VALID;
      if (REQ_VALID) begin
        diff_q <= TARGET - PC_PLUS4;
      end
    end
  end

  // Stage 2 / output register. Payload only reloads when stage 1 holds a
  // real request, so outputs stay put through stalls and bubbles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      v2        <= 1'b0;
      OFFSET    <= '0;
      ALIGN_ERR <= 1'b0;
      RANGE_ERR <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        OFFSET    <= chk_offset;
        ALIGN_ERR <= chk_align;
        RANGE_ERR <= chk_range;
      end
    end
  end

  // Error counter: counts erroneous responses as they are handed off and
  // sticks at all-ones rather than wrapping.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ERR_COUNT <= 8'd0;
    end else if (rsp_xfer && (ALIGN_ERR || RANGE_ERR) && (ERR_COUNT != 8'hFF)) begin
      ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

endmodule : branch_offset_encoder

// File: doc/branch_offset_encoder.md
# branch_offset_encoder

- Converts a branch target byte address into the 8-bit signed word-offset field used by the branch instruction format.
- Field semantics: `target = PC_PLUS4 + sign_extend(OFFSET) * 4`.
- Sits in the instruction-assembly / branch-patch path, ahead of the instruction memory writer.
- Two-stage valid/ready pipeline with range and alignment checking, plus a saturating error counter.

## Interface

Parameters:
- OFFSET_W, 8: width of the encoded offset field.
- ADDR_W, 32: address width.

Ports:
- CLK  input  1  sole clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  block accepts a request this cycle.
- PC_PLUS4  input  ADDR_W  address of the instruction following the branch.
- TARGET  input  ADDR_W  branch target byte address.
- RSP_VALID  output  1  response present.
- RSP_READY  input  1  consumer accepts the response.
- OFFSET  output  OFFSET_W  encoded word offset; valid only while RSP_VALID is high.
- ALIGN_ERR  output  1  target minus PC_PLUS4 is not a multiple of 4.
- RANGE_ERR  output  1  the word offset does not fit a signed OFFSET_W-bit field.
- ERR_COUNT  output  8  saturating count of erroneous responses handed off.

## Operation

- **Handshakes.** A request transfers on a cycle with REQ_VALID && REQ_READY. A response transfers on a cycle with RSP_VALID && RSP_READY.
- **Stage 1 (S1).** Registers `DIFF = TARGET - PC_PLUS4`, computed modulo 2^ADDR_W, together with valid bit V1.
- **Stage 2 (S2, output register).** Computes the following from DIFF and registers them with valid bit V2:
  - `OFFSET = DIFF[OFFSET_W+1:2]`.
  - `ALIGN_ERR = |DIFF[1:0]`.
  - `RANGE_ERR = 1` unless DIFF[ADDR_W-1:OFFSET_W+1] are all equal to DIFF[OFFSET_W+1]. For the defaults, the accepted DIFF range is -512 to +508.
- **Error precedence.** Both error flags may be set together. OFFSET still carries the truncated bits when an error flag is set; consumers must not use it in that case.
- **Pipeline advance.**
  - `adv2 = !V2 || RSP_READY`.
  - `adv1 = !V1 || adv2`.
  - `REQ_READY = adv1`. This is combinational from RSP_READY and state; there is no combinational path from REQ_VALID.
- **No holes.** S1 moves into S2 whenever adv2 is high. A bubble in S1 is never held behind an empty S2.
- **Stall.** While RSP_VALID && !RSP_READY, OFFSET, ALIGN_ERR and RANGE_ERR hold stable.
- **ERR_COUNT.** Increments by 1 on each response transfer with ALIGN_ERR || RANGE_ERR. It saturates at 255 and never wraps.
- **No state machine.** Control is the valid bits only.

## Timing

- **Reset values.** V1 = V2 = 0, RSP_VALID = 0, OFFSET = 0, ALIGN_ERR = 0, RANGE_ERR = 0, ERR_COUNT = 0, DIFF = 0. REQ_READY reads 1 during and after reset.
- **Reset mid-operation.** All in-flight requests are discarded immediately, with no response produced. ERR_COUNT clears.
- **Latency.** A request accepted at edge N gives RSP_VALID high after edge N+1, provided S2 was free.
- **Throughput.** One transfer per cycle when RSP_READY is held high.
- **Full pipeline.** With V1 = V2 = 1 and RSP_READY = 0, REQ_READY = 0. Both stages hold.
- **Simultaneous events.** A response transfer and a request acceptance in the same cycle are legal. S2 takes S1's contents and S1 takes the new request.
- **Address wrap-around.** PC_PLUS4 = 0x0000_0000 with TARGET = 0xFFFF_FFFC gives DIFF = -4, so OFFSET = 0xFC with no error.

## Structure

- Shared package `branch_pkg`:
  - OFFSET_W and ADDR_W defaults.
  - Localparams for the minimum and maximum byte offset (-512 and +508).
  - A packed response struct: offset, align_err, range_err.
- One sub-module: `offset_range_check`. It is combinational, takes DIFF, and returns offset, align_err and range_err. The same sub-module is reused by the assembler checker.
- The top level holds the two pipeline registers, the handshake logic and the error counter.

## Test plan

- **In-range forward and backward.**
  - PC_PLUS4 = 0x100, TARGET = 0x104 -> OFFSET = 0x01, no errors, response one edge after acceptance.
  - PC_PLUS4 = 0x100, TARGET = 0x0FC -> OFFSET = 0xFF, no errors.
- **Range boundaries (PC_PLUS4 = 0x100).**
  - TARGET = 0x2FC -> OFFSET = 0x7F, no error.
  - TARGET = 0x300 -> RANGE_ERR = 1.
  - TARGET = 0xFFFF_FF00 (DIFF = -512) -> OFFSET = 0x80, no error.
  - TARGET = 0xFFFF_FEFC -> RANGE_ERR = 1.
- **Misalignment.**
  - PC_PLUS4 = 0x100, TARGET = 0x102 -> ALIGN_ERR = 1, ERR_COUNT goes 0 -> 1 on the transfer.
  - 300 erroneous transfers -> ERR_COUNT = 255, no wrap.
- **Back-pressure.** Stream 4 requests with RSP_READY = 0.
  - REQ_READY drops after 2 acceptances.
  - Outputs stay stable during the stall.
  - Releasing RSP_READY delivers all 4 in order with no loss or duplication.
- **Full throughput.** 16 back-to-back requests with RSP_READY = 1 -> 16 responses on consecutive cycles, in order.
- **Reset mid-operation.** Both stages valid, then RESET is pulsed asynchronously between edges.
  - RSP_VALID falls immediately and ERR_COUNT = 0.
  - No stale response appears after RESET is deasserted.
